// File: rtl/multibyte_add_pkg.sv
// Shared types for the byte-serial multi-byte adder sequencer.
// Holds the FSM state encoding and the lane width.
package multibyte_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/multibyte_add_byte_idx_counter.sv
// Byte-lane index counter with clear, enable and terminal flag.
// Saturates at NUM_BYTES-1 so the index never wraps.
module byte_idx_counter #(
  parameter int NUM_BYTES = 4,
  localparam int IW = $clog2(NUM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (en && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NUM_BYTES-wide adder driving an external 8-bit adder.
// Optional MULTIBYTE_ADD_SIGNED_OVF_EN adds a registered signed-overflow flag.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NUM_BYTES = 4,
  localparam int W = BYTE_W * NUM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      op_a,
  input  logic [W-1:0]      op_b,
  input  logic              cin,
  output logic [BYTE_W-1:0] add_a,
  output logic [BYTE_W-1:0] add_b,
  output logic              add_cin,
  input  logic [BYTE_W-1:0] add_sum,
  input  logic              add_cout,
  output logic [W-1:0]      result,
  output logic              cout,
  output logic              busy,
  output logic              done,
  output logic              signed_ovf
);

  localparam int IW = $clog2(NUM_BYTES);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic          carry_q;
  logic          clr, en, last;
  logic [IW-1:0] idx;
  int            sel;

  assign sel = int'(idx) * BYTE_W;

  byte_idx_counter #(.NUM_BYTES(NUM_BYTES)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .en    (en),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        busy    = 1'b1;
        en      = 1'b1;
        add_a   = a_q[sel +: BYTE_W];
        add_b   = b_q[sel +: BYTE_W];
        add_cin = carry_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      if (clr) begin
        a_q     <= op_a;
        b_q     <= op_b;
        carry_q <= cin;
      end
      if (en) begin
        result[sel +: BYTE_W] <= add_sum;
        carry_q <= add_cout;
        if (last) cout <= add_cout;
      end
    end
  end

`ifdef MULTIBYTE_ADD_SIGNED_OVF_EN
  logic sovf_q;
  logic a_msb, b_msb;

  assign a_msb      = a_q[W-1];
  assign b_msb      = b_q[W-1];
  assign signed_ovf = sovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sovf_q <= 1'b0;
    end else if (en && last) begin
      sovf_q <= (a_msb == b_msb) && (add_sum[BYTE_W-1] != a_msb);
    end
  end
`else
  assign signed_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq with NUM_BYTES=4.
// An 8-bit ripple adder is modelled inline on the add_* ports.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

`ifdef MULTIBYTE_ADD_SIGNED_OVF_EN
  localparam bit SOVF_ON = 1'b1;
`else
  localparam bit SOVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic [W-1:0] result;
  logic         cout, busy, done, signed_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multibyte_add_seq #(.NUM_BYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .result     (result),
    .cout       (cout),
    .busy       (busy),
    .done       (done),
    .signed_ovf (signed_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_s, input bit inject);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_nodone"}, 64'(done), 64'd0);
      if (inject && i == 1) begin
        start = 1'b1;
        op_a  = 32'h1111_1111;
        op_b  = 32'h2222_2222;
        cin   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_dbusy"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'(exp_r));
    chk({tag, "_cout"}, 64'(cout), 64'(exp_c));
    chk({tag, "_sovf"}, 64'(signed_ovf), 64'(exp_s & SOVF_ON));
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_hold"}, 64'(result), 64'(exp_r));
    chk({tag, "_hold_c"}, 64'(cout), 64'(exp_c));
  endtask

  initial begin
    #13;
    rst = 1'b1;
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sovf", 64'(signed_ovf), 64'd0);
    chk("rst_adda", 64'(add_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);

    run_op("ff_p1", 32'h0000_00FF, 32'h0000_0001, 1'b0,
           32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
           32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("msb_msb", 32'h8000_0000, 32'h8000_0000, 1'b0,
           32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("inject", 32'h0F0F_0F0F, 32'h0101_0101, 1'b0,
           32'h1010_1010, 1'b0, 1'b0, 1'b1);

    // abort in the second ADD cycle
    @(negedge clk);
    op_a  = 32'hAAAA_AAAA;
    op_b  = 32'h5555_5555;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_addcin", 64'(add_cin), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NB + 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_nodone", 64'(done), 64'd0);
    end

    run_op("after_abort", 32'h1234_5678, 32'h1111_1111, 1'b0,
           32'h2345_6789, 1'b0, 1'b0, 1'b0);
    run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
           32'h8000_0000, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
